// File: rtl/fifo_read_stream_adapter_if.sv
// FIFO read-side and output stream signals of the read stream adapter.
// Stream: a beat moves on every clk edge where outValid && outReady; once raised,
// outValid holds with outData stable until that edge, and never depends on outReady.
interface fifo_read_stream_adapter_if #(
  parameter int DATAWIDTH  = 8,
  parameter int LEVELWIDTH = 2
);
  logic                  fifoEmpty;
  logic [DATAWIDTH-1:0]  fifoDataOut;
  logic                  fifoReadReq;
  logic                  outReady;
  logic                  outValid;
  logic [DATAWIDTH-1:0]  outData;
  logic [LEVELWIDTH-1:0] bufLevel;

  modport master (
    input  fifoEmpty, fifoDataOut, outReady,
    output fifoReadReq, outValid, outData, bufLevel
  );

  modport slave (
    output fifoEmpty, fifoDataOut, outReady,
    input  fifoReadReq, outValid, outData, bufLevel
  );
endinterface

// File: rtl/fifo_read_stream_adapter.sv
// Converts a one-cycle-latency FIFO read port into a valid/ready stream using a
// small circular skid buffer that absorbs the read latency at full throughput.
module fifo_read_stream_adapter #(
  parameter int DATAWIDTH  = 8,
  parameter int BUFDEPTH   = 2,
  parameter int LEVELWIDTH = $clog2(BUFDEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  fifo_read_stream_adapter_if.master bus
);
  localparam int PTRWIDTH = $clog2(BUFDEPTH);
  localparam int OCCWIDTH = LEVELWIDTH + 1;

  logic [DATAWIDTH-1:0]  mem_q [BUFDEPTH];
  logic [PTRWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVELWIDTH-1:0] level_q, level_d;
  logic                  in_flight_q;
  logic                  out_valid;
  logic                  pop_now;
  logic                  capture;
  logic                  read_req;
  logic [OCCWIDTH-1:0]   occupancy;

  function automatic logic [PTRWIDTH-1:0] next_ptr(input logic [PTRWIDTH-1:0] p);
    return (p == PTRWIDTH'(BUFDEPTH - 1)) ? '0 : p + PTRWIDTH'(1);
  endfunction

  assign out_valid = (level_q != '0);
  assign pop_now   = out_valid && bus.outReady;

  // Space still claimable after this cycle's transfer; a pop is only issued when
  // the returning word is guaranteed a slot.
  assign occupancy = OCCWIDTH'(level_q) + OCCWIDTH'(in_flight_q) - OCCWIDTH'(pop_now);
  assign read_req  = !reset && !flush && !bus.fifoEmpty &&
                     (occupancy < OCCWIDTH'(BUFDEPTH));
  assign capture   = in_flight_q && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (capture) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_now) rd_ptr_d = next_ptr(rd_ptr_q);
    if (capture && !pop_now) begin
      level_d = level_q + LEVELWIDTH'(1);
    end else if (!capture && pop_now) begin
      level_d = level_q - LEVELWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUFDEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_flight_q <= 1'b0;
    end else if (flush) begin
      // In-flight word is dropped by clearing in_flight_q and suppressing capture.
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_flight_q <= 1'b0;
    end else begin
      if (capture) mem_q[wr_ptr_q] <= bus.fifoDataOut;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_flight_q <= read_req;
    end
  end

  assign bus.fifoReadReq = read_req;
  assign bus.outValid    = out_valid;
  assign bus.outData     = mem_q[rd_ptr_q];
  assign bus.bufLevel    = level_q;
endmodule

// File: doc/fifo_read_stream_adapter.md
Name: fifo_read_stream_adapter

Overview:
- Sits directly downstream of the dual-clock FIFO, in the FIFO's read clock domain.
- Turns the FIFO read side (readReq / dataOut / empty, one-cycle read latency) into a valid/ready stream for consumer blocks (UART TX, DMA, bus bridges).
- Prefetches into a small circular skid buffer so the stream sustains one beat per clock while hiding FIFO read latency.
- Never pops the FIFO when buffer space for the returning word is not guaranteed.

Parameters:
- DATAWIDTH, 8, width of FIFO words and stream data.
- BUFDEPTH, 2, skid buffer entries; minimum 2; need not be a power of two.
- LEVELWIDTH, $clog2(BUFDEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  read-domain clock; same clock as the FIFO readClk.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of buffered and in-flight data.
- fifoEmpty  input  1  FIFO empty flag.
- fifoDataOut  input  DATAWIDTH  FIFO read data; valid the cycle after a pop.
- fifoReadReq  output  1  pop request to the FIFO.
- outReady  input  1  consumer accepts a beat.
- outValid  output  1  beat available.
- outData  output  DATAWIDTH  beat data.
- bufLevel  output  LEVELWIDTH  entries currently held in the skid buffer.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- State after reset: buffer empty, read/write pointers 0, inFlight 0, bufLevel 0, outValid 0, outData 0.
- fifoReadReq during reset: forced 0 combinationally.
- Pop rule: fifoReadReq = !reset && !flush && !fifoEmpty && (bufLevel + inFlight - popNow < BUFDEPTH).
  - popNow = outValid && outReady.
  - This combinational path from outReady is intentional and is what allows full throughput at BUFDEPTH 2.
  - Arithmetic is done at LEVELWIDTH+1 bits, so there is no underflow or overflow.
- inFlight: register loaded with fifoReadReq every cycle.
- Capture: when inFlight is 1 in cycle N+1, fifoDataOut is written at wrPtr in that cycle and wrPtr advances.
  - Read latency is exactly 1 cycle.
- Output: outValid = (bufLevel != 0). outData = entry at rdPtr.
  - Both come straight from registers or memory; there is no combinational path from outReady to outValid or outData.
- Stream rules:
  - Once outValid is 1 it stays 1, with outData stable, until accepted.
  - A beat is transferred on every cycle where outValid && outReady; rdPtr advances on each transfer.
- Pointers: wrap from BUFDEPTH-1 to 0. They are separate from bufLevel; bufLevel is the full/empty authority.
- Simultaneous capture and transfer:
  - bufLevel unchanged, both pointers advance.
  - With bufLevel 0, data cannot bypass the buffer: a captured word appears on outValid the next cycle.
- Latency: fifoEmpty falls in cycle N with the buffer empty → fifoReadReq in N, capture in N+1, outValid in N+2.
- Flush (one cycle):
  - Next cycle: bufLevel 0, pointers 0, outValid 0.
  - Any word returning from a pop issued before or in the flush cycle is discarded: inFlight is cleared and the capture is suppressed.
  - fifoReadReq is 0 in the flush cycle.
  - Popping resumes the cycle after the flush.
- Reset mid-operation: same effect as flush, plus outData cleared. A pop in flight is lost; the FIFO is expected to be reset together with this block.
- FIFO empty: no pop is issued while fifoEmpty is 1, even if buffer space exists. Any in-flight word is still captured.
- Buffer full: bufLevel = BUFDEPTH → no pop unless a transfer happens the same cycle. The buffer never overflows.
- Invariant: bufLevel + inFlight ≤ BUFDEPTH at every edge.

Test Plan:
- Reset, then FIFO preloaded with 0x11, 0x22, 0x33 and outReady held 1 → fifoReadReq high for 3 consecutive cycles. outValid high for 3 consecutive cycles, starting 2 cycles after the first pop. outData sequence 0x11, 0x22, 0x33. bufLevel never exceeds 1.
- FIFO holds 10 words, outReady 0 → exactly 2 pops, bufLevel saturates at 2, fifoReadReq stays 0, outData holds the first word stable. Raise outReady → remaining 10 words delivered in order at 1 beat/cycle.
- outReady toggling 1,0,1,0 over a 16-word stream → all 16 words in order, no duplicates or drops. bufLevel + inFlight ≤ 2 on every cycle (assertion).
- Assert flush in the cycle right after a pop, while bufLevel = 1 → the next cycle has bufLevel 0 and outValid 0. The returning word (e.g. 0x44) never appears on outData. The following FIFO word (0x55) is delivered next.
- BUFDEPTH 3, 7 words, outReady 0 until full, then 1 → pointers wrap 2→0 correctly. Output order preserved. bufLevel peaks at 3.
- Synchronous reset asserted mid-stream with inFlight 1 → fifoReadReq 0 in that cycle. Next cycle: outValid 0, bufLevel 0, outData 0. No capture of the in-flight word.
